// File: rtl/apb_completer_pkg.sv
// Shared types and constants for the APB completer memory block.
// Holds the transfer FSM encoding, data width, wait-state limits and the address check.
package apb_completer_pkg;

  localparam int DATA_W   = 32;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Request fields captured in the setup cycle and held for the access phase.
  typedef struct packed {
    logic [31:0]       addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  // A byte address is usable when word aligned and inside the 2**aw word array.
  function automatic logic addr_valid(input logic [31:0] addr, input int aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/apb_completer_ram.sv
// Single-port synchronous RAM, 2**AW words of DATA_W bits, one-cycle registered read.
// Write and read share the port; contents are deliberately not reset.
module apb_completer_ram
  import apb_completer_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_completer_mem.sv
// APB completer fronting a 2**MEM_AW x 32 RAM; transfer takes 2+WAIT_STATES cycles, PREADY low while waiting.
// Sticky PROT_ERR on protocol violations; APB_COMPLETER_SLVERR_EN enables PSLVERR for bad addresses.
module apb_completer_mem
  import apb_completer_pkg::*;
#(
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic [31:0]       PADDR,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              PROT_ERR
);

  localparam int             WS_EFF  = (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WS_EFF);

  apb_state_e        st_q, st_d, cur_st;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  apb_req_t          req_q, req_d;
  logic              prot_err_q, prot_err_d;

  logic              viol;
  logic              pready;
  logic              addr_ok;
  logic              ram_en;
  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign addr_ok = addr_valid(req_q.addr, MEM_AW);
  assign pready  = (st_q == ST_ACCESS) && (cnt_q == '0);

  // The setup cycle is the idle cycle in which the requester presents PSEL
  // without PENABLE, so SETUP is resolved from the live bus rather than stored.
  always_comb begin
    cur_st = st_q;
    if (st_q == ST_IDLE && PSEL && !PENABLE) begin
      cur_st = ST_SETUP;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    req_d = req_q;
    viol  = 1'b0;
    case (cur_st)
      ST_SETUP: begin
        st_d  = ST_ACCESS;
        req_d = '{addr: PADDR, write: PWRITE, wdata: PWDATA};
        cnt_d = WS_LOAD;
      end
      ST_ACCESS: begin
        viol = !PSEL || (PADDR != req_q.addr) || (PWRITE != req_q.write) ||
               (PWDATA != req_q.wdata);
        if (viol || cnt_q == '0) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        viol = PSEL && PENABLE;
        st_d = ST_IDLE;
      end
    endcase
    prot_err_d = prot_err_q | viol;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      prot_err_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      prot_err_q <= prot_err_d;
    end
  end

  // A write lands only on a clean completing access edge outside reset.
  assign ram_we   = PRESETN && pready && PSEL && PENABLE && req_q.write && addr_ok && !viol;
  assign ram_en   = (cur_st == ST_SETUP) || ram_we;
  assign ram_addr = (cur_st == ST_SETUP) ? PADDR[MEM_AW+1:2] : req_q.addr[MEM_AW+1:2];

  apb_completer_ram #(
    .AW(MEM_AW)
  ) u_ram (
    .clk  (PCLK),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(req_q.wdata),
    .rdata(ram_rdata)
  );

  assign PREADY   = pready;
  assign PRDATA   = (pready && !req_q.write && addr_ok) ? ram_rdata : '0;
  assign PROT_ERR = prot_err_q;

`ifdef APB_COMPLETER_SLVERR_EN
  assign PSLVERR = pready && !addr_ok;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule
